// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: stalls the pipeline over a req/ack memory port and returns load data.
// Latency: stall is held for the request cycle plus every ACCESS cycle (minimum 2); an unanswered access is abandoned after TIMEOUT cycles.
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mem_op;
  logic             aligned;

  assign mem_op  = MemRead_i | MemWrite_i;
  assign aligned = (addr_i[1:0] == 2'b00);

  // Gated by reset so nothing is requested or stalled while reset is asserted.
  assign mem_req_o  = rst_i && (state == ACCESS);
  assign stall_o    = rst_i && ((state == ACCESS) || ((state == IDLE) && mem_op && aligned));
  assign misalign_o = rst_i && (state == IDLE) && mem_op && !aligned;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= 1'b0;
      rdata_o     <= '0;
      timeout_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && aligned) begin
            mem_addr_o  <= addr_i;
            mem_wdata_o <= wdata_i;
            mem_we_o    <= MemWrite_i;
            cnt         <= '0;
            state       <= ACCESS;
          end else begin
            rdata_o <= '0;
          end
        end
        ACCESS: begin
          // An ack coinciding with the final wait cycle takes priority over the timeout.
          if (mem_ack_i) begin
            if (!mem_we_o) rdata_o <= mem_rdata_i;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            timeout_o <= 1'b1;
            rdata_o   <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios then random transactions against a per-transaction model.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, mem_we, stall, misalign, timeout;
  logic [31:0] mem_addr, mem_wdata, rdata;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] exp_rd = '0;
  logic        exp_to = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .addr_i(addr), .wdata_i(wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .stall_o(stall), .rdata_o(rdata),
    .misalign_o(misalign), .timeout_o(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One instruction through MEM: k is the 0-based ACCESS cycle carrying the ack (k<0 or k>=TO: never).
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int k, input logic [31:0] rdat);
    logic op, al, done, acked;
    int   nst, nreq, exp_st;
    op = rd | wr;
    al = (a[1:0] == 2'b00);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #1;
    if (op && al) begin
      chk("req_stall", {31'b0, stall}, 32'd1);
      chk("req_nomis", {31'b0, misalign}, 32'd0);
      chk("req_noreq", {31'b0, mem_req}, 32'd0);
      nst = 1; nreq = 0; done = 1'b0;
      for (int c = 1; c <= TO + 3 && !done; c++) begin
        @(negedge clk);
        mem_ack   = (c - 1 == k);
        mem_rdata = (c - 1 == k) ? rdat : $urandom;
        #1;
        if (!stall) done = 1'b1;
        else begin
          nst++;
          if (mem_req) nreq++;
          if (c == 1) begin
            chk("mem_addr", mem_addr, a);
            chk("mem_we", {31'b0, mem_we}, {31'b0, wr});
            chk("mem_wdata", mem_wdata, wd);
          end
        end
      end
      acked  = (k >= 0) && (k < TO);
      exp_st = acked ? k + 2 : TO + 1;
      if (!acked) begin
        exp_rd = '0;
        exp_to = 1'b1;
      end else if (!wr) begin
        exp_rd = rdat;
      end
      chk("done_reached", {31'b0, done}, 32'd1);
      chk("stall_cycles", nst, exp_st);
      chk("req_cycles", nreq, exp_st - 1);
      chk("done_noreq", {31'b0, mem_req}, 32'd0);
      chk("done_rdata", rdata, exp_rd);
      chk("done_timeout", {31'b0, timeout}, {31'b0, exp_to});
    end else begin
      chk("idle_misalign", {31'b0, misalign}, {31'b0, op});
      chk("idle_stall", {31'b0, stall}, 32'd0);
      chk("idle_req", {31'b0, mem_req}, 32'd0);
      exp_rd = '0;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk("idle_rdata", rdata, exp_rd);
      chk("idle_timeout", {31'b0, timeout}, {31'b0, exp_to});
    end
  endtask

  initial begin
    logic [31:0] ra;
    int          op, k;

    // Reset held with a load pending.
    mem_read = 1'b1; addr = 32'h40;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0;
    #1;
    chk("post_rst_stall", {31'b0, stall}, 32'd0);

    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF);
    run_txn(1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678, 0, 32'hFFFF_0000);
    run_txn(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0);
    run_txn(1'b1, 1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 1, 32'h1111_2222);
    run_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, TO - 1, 32'h0000_55AA);

    // Reset on the 2nd ACCESS cycle, late ack afterwards.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h80; mem_ack = 1'b0;
    #1 chk("mid_req_stall", {31'b0, stall}, 32'd1);
    @(negedge clk); #1 chk("mid_acc1_req", {31'b0, mem_req}, 32'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("mid_req_dropped", {31'b0, mem_req}, 32'd0);
    chk("mid_stall", {31'b0, stall}, 32'd0);
    @(negedge clk); mem_ack = 1'b0;
    #1;
    chk("mid_rdata", rdata, 32'd0);
    exp_rd = '0; exp_to = 1'b0;

    run_txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, -1, 32'h0);
    run_txn(1'b0, 1'b0, 32'h0000_0008, 32'h0, 0, 32'h0);

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 3);
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      k = $urandom_range(0, TO + 1);
      run_txn(op[0], op[1], ra, $urandom, k, $urandom);
    end

    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("final_rst_timeout", {31'b0, timeout}, 32'd0);
    chk("final_rst_rdata", rdata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
